// File: rtl/seq_divider4_pkg.sv
// Shared definitions for the sequential 4-bit divider: state encoding,
// operand width and the quotient reported on divide-by-zero.
package seq_divider4_pkg;
  localparam int WIDTH = 4;

  typedef logic [WIDTH-1:0] nibble_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam nibble_t DBZ_QUOTIENT = 4'hF;
endpackage

// File: rtl/fullsubtractor.sv
// 4-bit adder/subtractor: i_s=1 computes i_a - i_b with o_cout=1 meaning
// no borrow (i_a >= i_b); i_s=0 computes i_a + i_b.
module fullsubtractor
  import seq_divider4_pkg::*;
(
  input  logic    i_s,
  input  nibble_t i_a,
  input  nibble_t i_b,
  output nibble_t o_sum,
  output logic    o_cout
);
  logic [WIDTH:0] w_total;
  logic [WIDTH-1:0] w_b_eff;

  // Two's-complement subtract: invert B and inject the carry-in.
  assign w_b_eff = i_b ^ {WIDTH{i_s}};
  assign w_total = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_s};
  assign o_sum   = w_total[WIDTH-1:0];
  assign o_cout  = w_total[WIDTH];
endmodule

// File: rtl/seq_divider4.sv
// Multi-cycle unsigned 4-bit restoring divider, one quotient bit per cycle,
// built around the shared subtractor with a start/busy/done handshake.
module seq_divider4
  import seq_divider4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       dbz
);
  logic [1:0] r_state;
  logic [1:0] r_count;
  nibble_t    r_rem;
  nibble_t    r_q;
  nibble_t    r_dvd;
  nibble_t    r_dvs;
  nibble_t    r_quotient;
  nibble_t    r_remainder;
  logic       r_dbz;
  logic       r_dbz_pend;

  nibble_t    w_t;
  nibble_t    w_sub;
  nibble_t    w_rem_next;
  nibble_t    w_q_next;
  logic       w_cout;
  logic       w_take;
  logic       w_accept;

  // Dividend bits are consumed MSB-first by shifting r_dvd left.
  assign w_t = {r_rem[2:0], r_dvd[3]};

  fullsubtractor u_sub (
    .i_s    (1'b1),
    .i_a    (w_t),
    .i_b    (r_dvs),
    .o_sum  (w_sub),
    .o_cout (w_cout)
  );

  // A set R[3] means T overflowed 4 bits, so it certainly exceeds the divisor.
  assign w_take     = r_rem[3] | w_cout;
  assign w_rem_next = w_take ? w_sub : w_t;
  assign w_q_next   = {r_q[2:0], w_take};
  assign w_accept   = start && !r_dbz_pend &&
                      ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_count     <= 2'd0;
      r_rem       <= '0;
      r_q         <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_dbz_pend  <= 1'b0;
    end else begin
      case (r_state)
        ST_CALC: begin
          r_rem   <= w_rem_next;
          r_q     <= w_q_next;
          r_dvd   <= {r_dvd[2:0], 1'b0};
          r_count <= r_count + 2'd1;
          if (r_count == 2'd3) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_rem_next;
            r_dbz       <= 1'b0;
            r_state     <= ST_DONE;
          end
        end
        default: begin
          // Divide-by-zero settles one cycle after acceptance with busy low.
          if (r_dbz_pend) begin
            r_dbz_pend  <= 1'b0;
            r_quotient  <= DBZ_QUOTIENT;
            r_remainder <= r_dvd;
            r_dbz       <= 1'b1;
            r_state     <= ST_DONE;
          end else if (w_accept) begin
            r_dvd <= dividend;
            r_dvs <= divisor;
            r_rem <= '0;
            r_q   <= '0;
            r_count <= 2'd0;
            if (divisor != 4'd0) begin
              r_state <= ST_CALC;
            end else begin
              r_dbz_pend <= 1'b1;
              r_state    <= ST_IDLE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy      = (r_state == ST_CALC);
  assign done      = (r_state == ST_DONE);
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign dbz       = r_dbz;
endmodule

// File: tb/tb_seq_divider4.sv
// Randomized and directed bench for seq_divider4 against an arithmetic
// reference (n/d, n%d, DBZ convention) with handshake timing checks.
module tb_seq_divider4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dividend = 4'd0;
  logic [3:0] divisor = 4'd0;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       dbz;

  int n_vec = 0;
  int n_err = 0;

  seq_divider4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait (sampling #1 after each edge) until done, counting busy cycles.
  task automatic wait_done(inout int lat, inout int busy_cnt);
    while (done !== 1'b1 && lat < 12) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [3:0] n, input logic [3:0] d);
    int lat;
    int busy_cnt;
    int exp_q;
    int exp_r;
    int exp_lat;
    if (d == 4'd0) begin
      exp_q = 15; exp_r = int'(n); exp_lat = 1;
    end else begin
      exp_q = int'(n) / int'(d); exp_r = int'(n) % int'(d); exp_lat = 4;
    end
    @(negedge clk);
    start = 1'b1; dividend = n; divisor = d;
    @(posedge clk); #1;
    start = 1'b0; dividend = 4'($urandom); divisor = 4'($urandom);
    lat = 0; busy_cnt = 0;
    wait_done(lat, busy_cnt);
    chk("latency", lat, exp_lat);
    chk("busy_cycles", busy_cnt, (d == 4'd0) ? 0 : 4);
    chk("quotient", int'(quotient), exp_q);
    chk("remainder", int'(remainder), exp_r);
    chk("dbz", int'(dbz), (d == 4'd0) ? 1 : 0);
    if (d != 4'd0) begin
      chk("q_times_d_plus_r", int'(quotient) * int'(d) + int'(remainder), int'(n));
      chk("r_below_d", (int'(remainder) < int'(d)) ? 1 : 0, 1);
    end
    $display("op %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", n, d, quotient, remainder, dbz, lat);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    chk("busy_after_done", int'(busy), 0);
    chk("quotient_held", int'(quotient), exp_q);
  endtask

  initial begin
    int lat;
    int busy_cnt;

    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(dbz), 0);
    @(negedge clk); rst_n = 1'b1;

    run_op(4'd13, 4'd4);
    run_op(4'd15, 4'd1);
    run_op(4'd15, 4'd15);
    run_op(4'd7, 4'd9);
    run_op(4'd9, 4'd0);
    run_op(4'd6, 4'd3);

    // Start pulsed mid-CALC must be ignored.
    @(negedge clk); start = 1'b1; dividend = 4'd10; divisor = 4'd3;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1; dividend = 4'd15; divisor = 4'd1;
    @(posedge clk); #1; start = 1'b0;
    lat = 2; busy_cnt = 0;
    wait_done(lat, busy_cnt);
    chk("ignore_latency", lat, 4);
    chk("ignore_quotient", int'(quotient), 3);
    chk("ignore_remainder", int'(remainder), 1);
    $display("op 10/3 with mid-CALC start -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    @(posedge clk); #1;
    chk("ignore_no_restart", int'(busy), 0);

    // Start held through the DONE cycle: second op accepted back-to-back.
    @(negedge clk); start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(posedge clk); #1; dividend = 4'd5; divisor = 4'd2;
    lat = 0; busy_cnt = 0;
    wait_done(lat, busy_cnt);
    chk("b2b_first_latency", lat, 4);
    chk("b2b_first_quotient", int'(quotient), 4);
    chk("b2b_first_remainder", int'(remainder), 2);
    $display("op 14/3 (b2b first) -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    @(posedge clk); #1; start = 1'b0;
    chk("b2b_busy_after_accept", int'(busy), 1);
    lat = 0; busy_cnt = 0;
    wait_done(lat, busy_cnt);
    chk("b2b_second_latency", lat, 4);
    chk("b2b_second_busy", busy_cnt, 4);
    chk("b2b_second_quotient", int'(quotient), 2);
    chk("b2b_second_remainder", int'(remainder), 1);
    $display("op 5/2 (b2b second) -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    @(posedge clk); #1;
    chk("b2b_done_drops", int'(done), 0);

    // Asynchronous reset at count=2 of 12/5.
    @(negedge clk); start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    chk("async_quotient", int'(quotient), 0);
    chk("async_remainder", int'(remainder), 0);
    chk("async_dbz", int'(dbz), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_no_done", int'(done), 0);
    end
    $display("reset mid-CALC of 12/5 -> q=%0d r=%0d done=%0d", quotient, remainder, done);
    @(negedge clk); rst_n = 1'b1;
    run_op(4'd12, 4'd5);

    for (int n = 0; n < 16; n++) begin
      for (int d = 0; d < 16; d++) begin
        run_op(4'(n), 4'(d));
      end
    end

    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom), 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
